// File: rtl/anfsqrt_pkg.sv
// Shared constants and state encoding for the square-root scheduler.
package anfsqrt_pkg;

  // Width of every datapath word (query, result, iterator state).
  localparam int SQ_W = 7;

  // Initial trial bit loaded into the iterator on accept.
  localparam logic [SQ_W-1:0] ATT_INIT = 7'h10;

  // Default number of iterator applications per query.
  localparam int ITERS_DEFAULT = 7;

  // Scheduler states.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2
  } state_e;

endpackage : anfsqrt_pkg

// File: rtl/anfsqrt_rr_arb.sv
// Round-robin priority pick: searches upward from i_ptr+1 with wrap-around
// and returns a one-hot grant plus its index.
module anfsqrt_rr_arb #(
  parameter int N   = 4,
  parameter int IDW = $clog2(N)
) (
  input  logic [N-1:0]   i_req,
  input  logic [IDW-1:0] i_ptr,
  output logic [N-1:0]   o_gnt,
  output logic [IDW-1:0] o_idx,
  output logic           o_any
);

  // Walk candidates from farthest to nearest so the nearest requester after
  // the pointer is the last (winning) assignment.
  always_comb begin
    int w_idx;
    // NOTE: every output gets a default before the loop so no path leaves a
    // value unassigned, which would otherwise infer a latch.
    o_gnt = '0;
    o_idx = '0;
    o_any = 1'b0;
    w_idx = 0;
    for (int k = N; k >= 1; k--) begin
      w_idx = int'(i_ptr) + k;
      if (w_idx >= N) w_idx = w_idx - N;
      if (i_req[w_idx]) begin
        o_gnt        = '0;
        o_gnt[w_idx] = 1'b1;
        o_idx        = IDW'(w_idx);
        o_any        = 1'b1;
      end
    end
  end

endmodule : anfsqrt_rr_arb

// File: rtl/anfsqrt_sqrtiu.sv
// Combinational square-root iterator stage: one bit-trial step per application.
// The trial value res|att is kept when its square does not exceed the operand;
// att then walks one bit lower. eps carries the operand through unchanged.
module anfsqrt_sqrtiu
  import anfsqrt_pkg::*;
(
  input  logic [SQ_W-1:0] i_att,
  input  logic [SQ_W-1:0] i_eps,
  input  logic [SQ_W-1:0] i_res,
  output logic [SQ_W-1:0] o_this_att,
  output logic [SQ_W-1:0] o_this_eps,
  output logic [SQ_W-1:0] o_this_res
);

  logic [SQ_W-1:0]   w_try;
  logic [2*SQ_W-1:0] w_sq;

  assign w_try = i_res | i_att;
  assign w_sq  = {{SQ_W{1'b0}}, w_try} * {{SQ_W{1'b0}}, w_try};

  // One trial step: accept the trial bit if its square still fits under eps.
  always_comb begin
    o_this_att = i_att >> 1;
    o_this_eps = i_eps;
    o_this_res = (w_sq <= {{SQ_W{1'b0}}, i_eps}) ? w_try : i_res;
  end

endmodule : anfsqrt_sqrtiu

// File: rtl/anfsqrt_sched.sv
// Round-robin scheduler sharing one square-root iterator between NREQ
// requesters: accept one query, iterate ITERS times, hold the tagged result
// until the consumer takes it.
module anfsqrt_sched
  import anfsqrt_pkg::*;
#(
  parameter int NREQ  = 4,
  parameter int ITERS = ITERS_DEFAULT,
  parameter int IDW   = $clog2(NREQ)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NREQ-1:0]      req_valid,
  input  logic [SQ_W*NREQ-1:0] req_query,
  output logic [NREQ-1:0]      req_ready,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [SQ_W-1:0]      rsp_result,
  output logic [IDW-1:0]       rsp_id,
  output logic                 busy
);

  localparam int               CNT_W    = (ITERS > 1) ? $clog2(ITERS) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ITERS - 1);

  state_e           r_state;
  state_e           w_state_nxt;
  logic [SQ_W-1:0]  r_att;
  logic [SQ_W-1:0]  r_eps;
  logic [SQ_W-1:0]  r_res;
  logic [SQ_W-1:0]  r_result;
  logic [CNT_W-1:0] r_cnt;
  logic [IDW-1:0]   r_ptr;
  logic [IDW-1:0]   r_id;
  logic             r_rsp_valid;

  logic [NREQ-1:0]  w_gnt;
  logic [IDW-1:0]   w_gnt_idx;
  logic             w_any;
  logic             w_accept;
  logic             w_last;
  logic [SQ_W-1:0]  w_query;
  logic [SQ_W-1:0]  w_this_att;
  logic [SQ_W-1:0]  w_this_eps;
  logic [SQ_W-1:0]  w_this_res;

  anfsqrt_rr_arb #(
    .N   (NREQ),
    .IDW (IDW)
  ) u_arb (
    .i_req (req_valid),
    .i_ptr (r_ptr),
    .o_gnt (w_gnt),
    .o_idx (w_gnt_idx),
    .o_any (w_any)
  );

  anfsqrt_sqrtiu u_sqrtiu (
    .i_att      (r_att),
    .i_eps      (r_eps),
    .i_res      (r_res),
    .o_this_att (w_this_att),
    .o_this_eps (w_this_eps),
    .o_this_res (w_this_res)
  );

  assign w_query  = req_query[SQ_W*int'(w_gnt_idx) +: SQ_W];
  assign w_accept = (r_state == IDLE) && w_any;
  assign w_last   = (r_cnt == CNT_LAST);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: state is updated with non-blocking assignments so every flop
    // samples pre-edge values, independent of block evaluation order.
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next-state and handshake outputs.
  always_comb begin
    w_state_nxt = r_state;
    req_ready   = '0;
    busy        = 1'b1;
    case (r_state)
      IDLE: begin
        busy      = 1'b0;
        req_ready = w_gnt;
        if (w_any) w_state_nxt = RUN;
      end
      RUN:     if (w_last) w_state_nxt = HOLD;
      HOLD:    if (rsp_ready) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Datapath: load on accept, iterate in RUN, hold the result until taken.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: all registers here are plain flops (no memory arrays), so each
    // one is cleared by reset; an in-flight query is simply discarded.
    if (!rst_n) begin
      r_att       <= '0;
      r_eps       <= '0;
      r_res       <= '0;
      r_cnt       <= '0;
      r_result    <= '0;
      r_id        <= '0;
      r_ptr       <= IDW'(NREQ - 1);
      r_rsp_valid <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_eps <= w_query;
            r_att <= ATT_INIT;
            r_res <= '0;
            r_cnt <= '0;
            r_id  <= w_gnt_idx;
            r_ptr <= w_gnt_idx;
          end
        end
        RUN: begin
          r_att <= w_this_att;
          r_eps <= w_this_eps;
          r_res <= w_this_res;
          r_cnt <= r_cnt + 1'b1;
          if (w_last) begin
            r_result    <= w_this_res;
            r_rsp_valid <= 1'b1;
          end
        end
        HOLD: begin
          if (rsp_ready) r_rsp_valid <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign rsp_valid  = r_rsp_valid;
  assign rsp_result = r_result;
  assign rsp_id     = r_id;

endmodule : anfsqrt_sched

// File: tb/tb_anfsqrt_sched.sv
// Directed self-checking bench for anfsqrt_sched (NREQ=4, ITERS=7).
module tb_anfsqrt_sched;

  localparam int NREQ  = 4;
  localparam int ITERS = 7;
  localparam int IDW   = 2;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [NREQ-1:0] req_valid;
  logic [7*NREQ-1:0] req_query;
  logic [NREQ-1:0] req_ready;
  logic            rsp_valid;
  logic            rsp_ready;
  logic [6:0]      rsp_result;
  logic [IDW-1:0]  rsp_id;
  logic            busy;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  anfsqrt_sched #(
    .NREQ  (NREQ),
    .ITERS (ITERS),
    .IDW   (IDW)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_query  (req_query),
    .req_ready  (req_ready),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_result (rsp_result),
    .rsp_id     (rsp_id),
    .busy       (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic set_query(input int i, input logic [6:0] v);
    req_query[7*i +: 7] = v;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst_n     = 1'b0;
    req_valid = '0;
    rsp_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Wait (at negedges) for any req_ready bit; a timeout is a failed check.
  task automatic wait_grant(input string name);
    int k;
    for (k = 0; k < 30; k++) begin
      if (req_ready !== '0) break;
      @(negedge clk);
    end
    if (k == 30) begin
      n_checks++; n_fail++;
      $display("FAIL %s: grant timeout, req_ready=%b required nonzero", name, req_ready);
    end
  endtask

  task automatic wait_rsp(input string name);
    int k;
    for (k = 0; k < 30; k++) begin
      if (rsp_valid === 1'b1) break;
      @(negedge clk);
    end
    if (k == 30) begin
      n_checks++; n_fail++;
      $display("FAIL %s: response timeout, rsp_valid=%b required 1", name, rsp_valid);
    end
  endtask

  task automatic test_reset();
    rst_n     = 1'b0;
    req_valid = '0;
    req_query = '0;
    rsp_ready = 1'b0;
    #1;
    n_checks++;
    if ({req_ready, rsp_valid, rsp_result, rsp_id, busy} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: ready=%b valid=%b result=%0d id=%0d busy=%b required all 0",
               req_ready, rsp_valid, rsp_result, rsp_id, busy);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_single();
    @(negedge clk);
    set_query(0, 7'd49);
    req_valid = 4'b0001;
    #1;
    n_checks++;
    if (req_ready !== 4'b0001) begin
      n_fail++; $display("FAIL single_grant: req_ready=%b required 0001", req_ready);
    end
    @(negedge clk);  // accept edge E0 has passed
    req_valid = '0;
    n_checks++;
    if (req_ready !== 4'b0000 || busy !== 1'b1) begin
      n_fail++; $display("FAIL single_after_accept: req_ready=%b busy=%b required 0000/1", req_ready, busy);
    end
    for (int c = 1; c <= ITERS; c++) begin
      @(negedge clk);
      n_checks++;
      if (rsp_valid !== (c == ITERS)) begin
        n_fail++; $display("FAIL single_latency: after E0+%0d rsp_valid=%b required %b", c, rsp_valid, c == ITERS);
      end
    end
    n_checks++;
    if (rsp_id !== 2'd0 || rsp_result !== 7'd7) begin
      n_fail++; $display("FAIL single_result: id=%0d result=%0d required 0/7", rsp_id, rsp_result);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    n_checks++;
    if (rsp_valid !== 1'b0 || busy !== 1'b0) begin
      n_fail++; $display("FAIL single_release: valid=%b busy=%b required 0/0", rsp_valid, busy);
    end
  endtask

  task automatic test_round_robin();
    logic [3:0] exp_gnt [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    logic [6:0] exp_res [4] = '{7'd3, 7'd4, 7'd5, 7'd6};
    int last_cyc;
    apply_reset();
    set_query(0, 7'd9);
    set_query(1, 7'd16);
    set_query(2, 7'd25);
    set_query(3, 7'd36);
    req_valid = 4'b1111;
    rsp_ready = 1'b1;
    last_cyc  = 0;
    #1;
    for (int g = 0; g < 5; g++) begin
      wait_grant("rr_grant");
      n_checks++;
      if (req_ready !== exp_gnt[g]) begin
        n_fail++; $display("FAIL rr_order: grant %0d req_ready=%b required %b", g, req_ready, exp_gnt[g]);
      end
      if (g > 0) begin
        n_checks++;
        if (cyc - last_cyc != ITERS + 2) begin
          n_fail++; $display("FAIL rr_interval: grant %0d interval=%0d required %0d", g, cyc - last_cyc, ITERS + 2);
        end
      end
      last_cyc = cyc;
      @(negedge clk);
      wait_rsp("rr_rsp");
      n_checks++;
      if (rsp_id !== IDW'(g % 4) || rsp_result !== exp_res[g % 4]) begin
        n_fail++; $display("FAIL rr_result: grant %0d id=%0d result=%0d required %0d/%0d",
                           g, rsp_id, rsp_result, g % 4, exp_res[g % 4]);
      end
      @(negedge clk);  // HOLD released by rsp_ready=1
    end
    req_valid = '0;
    rsp_ready = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_backpressure();
    // Pointer is at 0 after the round-robin run.
    set_query(0, 7'd49);
    set_query(2, 7'd25);
    req_valid = 4'b0001;
    #1;
    wait_grant("bp_grant0");
    @(negedge clk);
    req_valid = 4'b0100;
    wait_rsp("bp_rsp0");
    for (int c = 0; c < 20; c++) begin
      n_checks++;
      if (rsp_valid !== 1'b1 || rsp_result !== 7'd7 || rsp_id !== 2'd0 || req_ready !== 4'b0000) begin
        n_fail++; $display("FAIL bp_hold: cycle %0d valid=%b result=%0d id=%0d ready=%b required 1/7/0/0000",
                           c, rsp_valid, rsp_result, rsp_id, req_ready);
      end
      @(negedge clk);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    n_checks++;
    if (rsp_valid !== 1'b0 || req_ready !== 4'b0100) begin
      n_fail++; $display("FAIL bp_release: valid=%b req_ready=%b required 0/0100", rsp_valid, req_ready);
    end
    @(negedge clk);
    req_valid = '0;
    wait_rsp("bp_rsp2");
    n_checks++;
    if (rsp_id !== 2'd2 || rsp_result !== 7'd5) begin
      n_fail++; $display("FAIL bp_result2: id=%0d result=%0d required 2/5", rsp_id, rsp_result);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
  endtask

  task automatic test_reset_mid_run();
    int seen;
    // Pointer is at 2; requester 1 wins the search 3,0,1.
    set_query(1, 7'd100);
    req_valid = 4'b0010;
    #1;
    wait_grant("rst_grant");
    @(negedge clk);
    req_valid = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({req_ready, rsp_valid, rsp_result, rsp_id, busy} !== '0) begin
      n_fail++; $display("FAIL rst_mid_outputs: ready=%b valid=%b result=%0d id=%0d busy=%b required all 0",
                         req_ready, rsp_valid, rsp_result, rsp_id, busy);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    seen  = 0;
    rsp_ready = 1'b1;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (rsp_valid !== 1'b0) seen++;
    end
    rsp_ready = 1'b0;
    n_checks++;
    if (seen != 0) begin
      n_fail++; $display("FAIL rst_no_rsp: rsp_valid high %0d cycles required 0", seen);
    end
    req_valid = 4'b1011;
    #1;
    n_checks++;
    if (req_ready !== 4'b0001) begin
      n_fail++; $display("FAIL rst_priority: req_ready=%b required 0001", req_ready);
    end
    req_valid = '0;  // withdraw before the edge
    @(negedge clk);
  endtask

  task automatic test_query_sampling();
    // Pointer is back at 3 after reset; requester 1 wins.
    set_query(1, 7'd36);
    req_valid = 4'b0010;
    #1;
    wait_grant("qs_grant");
    @(negedge clk);
    req_valid = '0;
    set_query(1, 7'd100);
    @(negedge clk);
    set_query(1, 7'd127);
    wait_rsp("qs_rsp");
    n_checks++;
    if (rsp_id !== 2'd1 || rsp_result !== 7'd6) begin
      n_fail++; $display("FAIL qs_result: id=%0d result=%0d required 1/6", rsp_id, rsp_result);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
  endtask

  task automatic test_boundaries();
    logic [3:0] exp_gnt [2] = '{4'b1000, 4'b0010};
    logic [1:0] exp_id  [2] = '{2'd3, 2'd1};
    logic [6:0] exp_res [2] = '{7'd0, 7'd11};
    // Pointer is at 1: requester 3 (query 0) goes before requester 1 (query 127).
    set_query(3, 7'd0);
    set_query(1, 7'd127);
    req_valid = 4'b1010;
    #1;
    for (int g = 0; g < 2; g++) begin
      wait_grant("bd_grant");
      n_checks++;
      if (req_ready !== exp_gnt[g]) begin
        n_fail++; $display("FAIL bd_order: grant %0d req_ready=%b required %b", g, req_ready, exp_gnt[g]);
      end
      @(negedge clk);
      req_valid = req_valid & ~exp_gnt[g];
      wait_rsp("bd_rsp");
      n_checks++;
      if (rsp_id !== exp_id[g] || rsp_result !== exp_res[g]) begin
        n_fail++; $display("FAIL bd_result: grant %0d id=%0d result=%0d required %0d/%0d",
                           g, rsp_id, rsp_result, exp_id[g], exp_res[g]);
      end
      n_checks++;
      if ($isunknown({req_ready, rsp_valid, rsp_result, rsp_id, busy})) begin
        n_fail++; $display("FAIL bd_no_x: outputs ready=%b valid=%b result=%b id=%b busy=%b required no X",
                           req_ready, rsp_valid, rsp_result, rsp_id, busy);
      end
      rsp_ready = 1'b1;
      @(negedge clk);
      rsp_ready = 1'b0;
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_backpressure();
    test_reset_mid_run();
    test_query_sampling();
    test_boundaries();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_anfsqrt_sched
